reg_dump: RTL

//  Sequential read-out engine for the register file: on start it walks every RF address through the RF's
//  two combinational read ports and streams the contents out as 16-bit beats on a valid/ready interface.

---
 rtl/reg_dump.sv | 93 +++++++++
 1 files changed

// File: rtl/reg_dump.sv
// Sequential register-file read-out engine: walks RF address pairs through two read ports
// and streams {odd, even} bytes as 16-bit valid/ready beats, with a running mod-256 byte checksum.
module reg_dump #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd0_addr,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [7:0]        rd0_val,
  input  logic [7:0]        rd1_val,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  // Pointer of the final even/odd pair; wraps harmlessly to 0 when ADDR_W == 1.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(2 ** ADDR_W - 2);

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  // ptr is kept even, so the odd partner is just the LSB set.
  assign rd0_addr = ptr;
  assign rd1_addr = ptr | ADDR_W'(1);

  // NOTE: every register here is updated with <= so all of them see the pre-edge values
  // of each other; a blocking '=' would let later statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            ptr      <= '0;
            checksum <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          out_data  <= {rd1_val, rd0_val};
          out_valid <= 1'b1;
          out_last  <= (ptr == LAST_PTR);
          state     <= SEND;
        end
        SEND: begin
          // out_valid is always high here, so out_ready alone signals the accept.
          if (out_ready) begin
            checksum  <= checksum + out_data[7:0] + out_data[15:8];
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              ptr   <= ptr + ADDR_W'(2);
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ptr   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
